// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule and the round datapaths.
//   AES_NR / AES_NK : round count and key length in words for AES-128
//   AES_RCON        : round constants, indexed by the round being produced
//   word_t/block_t  : 32-bit word and 128-bit block types
//   state_t         : key-schedule FSM states
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // Entry 0 and entries 11..15 are never used for a real round; they are
    // zero-padded so a 4-bit round number can index the table directly.
    localparam logic [7:0] AES_RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
//   in_byte  : byte to substitute
//   out_byte : SubBytes(in_byte)
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128 key schedule: one round key per clock, rk[0]..rk[10].
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start, cipher_key   : expansion request and key (bits [127:96] = w0)
//   busy                : expansion in progress (covers every rk_valid cycle)
//   rk_valid, rk_index,
//   round_key, done     : streamed round keys; done marks rk_index = 10
//   keys_ready          : key file holds a complete schedule
//   rd_index, rd_key    : combinational random-access read of the key file
module aes_key_sched_seq
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter bit STORE_KEYS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cipher_key,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         done,
    output logic         keys_ready,
    input  logic [3:0]   rd_index,
    output logic [127:0] rd_key
);

    if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
        $fatal(1, "aes_key_sched_seq: only NUM_ROUNDS = 10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    block_t     words_q, words_d;
    logic [3:0] round_q, round_d;
    logic       keys_ready_q, keys_ready_d;

    word_t      w0, w1, w2, w3;
    word_t      rot_w3, sub_w3, t_word;
    word_t      w0_n, w1_n, w2_n, w3_n;
    logic [3:0] round_inc;

    assign w0 = words_q[127:96];
    assign w1 = words_q[95:64];
    assign w2 = words_q[63:32];
    assign w3 = words_q[31:0];

    // RotWord then SubWord on the last word of the current round key.
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < AES_NK; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w3[8*b +: 8]),
            .out_byte (sub_w3[8*b +: 8])
        );
    end

    // The constant belongs to the round being produced, hence round + 1.
    assign round_inc = round_q + 4'd1;
    assign t_word    = sub_w3 ^ {AES_RCON[round_inc], 24'h0};

    // Each new word chains off the one just produced.
    assign w0_n = w0 ^ t_word;
    assign w1_n = w1 ^ w0_n;
    assign w2_n = w2 ^ w1_n;
    assign w3_n = w3 ^ w2_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            words_q      <= '0;
            round_q      <= '0;
            keys_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_q      <= words_d;
            round_q      <= round_d;
            keys_ready_q <= keys_ready_d;
        end
    end

    // keys_ready rises on the edge that moves to the last round, so it is
    // already high in the done cycle; start in that cycle is ignored because
    // the FSM is still in EXPAND.
    always_comb begin
        state_d      = state_q;
        words_d      = words_q;
        round_d      = round_q;
        keys_ready_d = keys_ready_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = EXPAND;
                    words_d      = cipher_key;
                    round_d      = '0;
                    keys_ready_d = 1'b0;
                end
            end
            EXPAND: begin
                if (round_q == LAST_ROUND) begin
                    state_d = IDLE;
                    round_d = '0;
                end else begin
                    words_d = {w0_n, w1_n, w2_n, w3_n};
                    round_d = round_inc;
                    if (round_inc == LAST_ROUND) begin
                        keys_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rk_valid   = (state_q == EXPAND);
    assign busy       = rk_valid;
    assign rk_index   = rk_valid ? round_q : 4'd0;
    assign round_key  = rk_valid ? words_q : '0;
    assign done       = rk_valid && (round_q == LAST_ROUND);
    assign keys_ready = keys_ready_q;

    if (STORE_KEYS) begin : g_key_file
        block_t key_file [0:NUM_ROUNDS];

        // Registered write: a same-cycle read of the slot being written
        // still sees the previous contents.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= NUM_ROUNDS; i++) begin
                    key_file[i] <= '0;
                end
            end else if (rk_valid) begin
                key_file[round_q] <= words_q;
            end
        end

        assign rd_key = (rd_index <= LAST_ROUND) ? key_file[rd_index] : '0;
    end else begin : g_no_key_file
        assign rd_key = '0;
    end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Self-checking bench for aes_key_sched_seq. A reference model derived
// from the FIPS-197 word recurrence (with the S-box rebuilt from GF(2^8)
// inversion plus the affine map) fills a scoreboard; a monitor pops and
// compares every streamed round key.
module tb_aes_key_sched_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] cipher_key;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         done;
    logic         keys_ready;
    logic [3:0]   rd_index;
    logic [127:0] rd_key;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t         sb_q [$];
    int           checks = 0;
    int           errors = 0;
    int           cycle  = 0;
    int           accept_cycle = 0;
    logic [7:0]   sbox_tab [0:255];
    logic [7:0]   rcon_tab [1:10];
    logic [127:0] model_ks [0:10];
    logic [127:0] file_model [0:10];
    logic [127:0] stream_keys [0:10];

    aes_key_sched_seq #(
        .NUM_ROUNDS (10),
        .STORE_KEYS (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cipher_key (cipher_key),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_index   (rk_index),
        .round_key  (round_key),
        .done       (done),
        .keys_ready (keys_ready),
        .rd_index   (rd_index),
        .rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic buildTables();
        logic [7:0] inv;
        logic [7:0] r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
        r = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            rcon_tab[i] = r;
            r = gf_mul(r, 8'h02);
        end
    endtask

    task automatic computeSchedule(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_tab[temp[31:24]], sbox_tab[temp[23:16]],
                        sbox_tab[temp[15:8]], sbox_tab[temp[7:0]]};
                temp = temp ^ {rcon_tab[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= 10; r++) model_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] randKey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rk_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rk: got index %0d with no key expected", rk_index);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("rk_index", 128'(rk_index), 128'(e.idx));
                    checkOutput("round_key", round_key, e.key);
                    checkOutput("done_flag", 128'(done), 128'(e.idx == 4'd10));
                    checkOutput("busy_valid", 128'(busy), 128'd1);
                    stream_keys[e.idx] = round_key;
                end
            end else begin
                checkOutput("idle_done", 128'(done), 128'd0);
                checkOutput("idle_busy", 128'(busy), 128'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Call while the DUT is idle, just after a rising edge.
    task automatic applyStimulus(input logic [127:0] key);
        exp_t e;
        start      = 1'b1;
        cipher_key = key;
        @(posedge clk);
        #1;
        accept_cycle = cycle;
        start        = 1'b0;
        cipher_key   = randKey();
        computeSchedule(key);
        for (int r = 0; r <= 10; r++) begin
            e.idx = 4'(r);
            e.key = model_ks[r];
            sb_q.push_back(e);
        end
        checkOutput("keys_ready_clear", 128'(keys_ready), 128'd0);
        checkOutput("busy_after_start", 128'(busy), 128'd1);
    endtask

    task automatic waitDone();
        bit found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 20 cycles");
        end else begin
            checkOutput("done_cycle", 128'(cycle - accept_cycle + 1), 128'd11);
            checkOutput("keys_ready_at_done", 128'(keys_ready), 128'd1);
            for (int r = 0; r <= 10; r++) file_model[r] = model_ks[r];
        end
    endtask

    task automatic checkFile();
        for (int i = 10; i >= 0; i--) begin
            rd_index = 4'(i);
            #1;
            checkOutput($sformatf("rd_key[%0d]", i), rd_key, file_model[i]);
        end
        rd_index = 4'd11;
        #1;
        checkOutput("rd_key[11]", rd_key, 128'd0);
        rd_index = 4'd15;
        #1;
        checkOutput("rd_key[15]", rd_key, 128'd0);
        rd_index = 4'd0;
    endtask

    task automatic finishIdle();
        @(posedge clk);
        #1;
        checkOutput("keys_ready_after", 128'(keys_ready), 128'd1);
        checkOutput("busy_after", 128'(busy), 128'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        cipher_key = '0;
        rd_index   = 4'd0;
        for (int r = 0; r <= 10; r++) file_model[r] = '0;
        buildTables();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rk_valid", 128'(rk_valid), 128'd0);
        checkOutput("reset_round_key", round_key, 128'd0);
        checkOutput("reset_keys_ready", 128'(keys_ready), 128'd0);
        checkOutput("reset_rd_key", rd_key, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkFile();

        // FIPS-197 example key
        applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c);
        waitDone();
        finishIdle();
        checkOutput("fips_rk1", stream_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("fips_rk10", stream_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // All-zero key
        applyStimulus(128'h0);
        waitDone();
        finishIdle();
        checkOutput("zero_rk1", stream_keys[1], 128'h62636363626363636263636362636363);
        checkOutput("zero_rk10", stream_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Third known key, then reverse sweep of the key file
        applyStimulus(128'h0f1571c947d9e8590cb7add6af7f6798);
        waitDone();
        finishIdle();
        checkOutput("k3_rk1", stream_keys[1], 128'hdc9037b09b49dfe997fe723f388115a7);
        checkOutput("k3_rk10", stream_keys[10], 128'hb48ef352ba98134e7f4d592086261876);
        checkFile();

        // start at rk_index 4 with another key is ignored
        applyStimulus(randKey());
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_rk_index", 128'(rk_index), 128'd4);
        start      = 1'b1;
        cipher_key = randKey();
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone();

        // start in the done cycle is ignored, then accepted right after
        start      = 1'b1;
        cipher_key = randKey();
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("done_start_ignored", 128'(rk_valid), 128'd0);
        checkOutput("idle_gap_busy", 128'(busy), 128'd0);
        applyStimulus(randKey());
        waitDone();
        finishIdle();
        checkFile();

        // Reset in the middle of an expansion
        applyStimulus(randKey());
        repeat (6) @(posedge clk);
        #1;
        checkOutput("pre_reset_index", 128'(rk_index), 128'd6);
        #2;
        rst_n    = 1'b0;
        rd_index = 4'd0;
        #1;
        sb_q.delete();
        for (int r = 0; r <= 10; r++) file_model[r] = '0;
        checkOutput("rst_rk_valid", 128'(rk_valid), 128'd0);
        checkOutput("rst_rk_index", 128'(rk_index), 128'd0);
        checkOutput("rst_round_key", round_key, 128'd0);
        checkOutput("rst_done", 128'(done), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_keys_ready", 128'(keys_ready), 128'd0);
        checkOutput("rst_rd_key0", rd_key, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(randKey());
        waitDone();
        finishIdle();
        checkFile();

        // Random keys with random idle gaps
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            applyStimulus(randKey());
            waitDone();
            finishIdle();
            for (int j = 0; j < 3; j++) begin
                rd_index = 4'($urandom_range(0, 10));
                #1;
                checkOutput("rand_read", rd_key, file_model[rd_index]);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
